test_pattern_gen: RTL and testbench

Parametrised VGA test-pattern source for the display path. It generalises fixed colour bars to N bars, with four selectable patterns: static bars, horizontally scrolling bars, animated checkerboard and grey ramp. It sits between the VGA timing counter (x, y, frame_start) and the colour inputs of the VGA adapter. The datapath is a 2-stage registered pipeline, and all pattern state updates at frame boundaries.

---
 rtl/test_pattern_gen.sv | 171 +++++++++++++++++
 tb/tb_test_pattern_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
// VGA test-pattern source: static/scrolling colour bars, animated checkerboard and grey ramp.
// Pattern state changes only at frame_start; the pixel datapath is a 2-stage registered pipeline.
module test_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int NUM_BARS    = 8,
  parameter int COLOR_W     = 10,
  parameter int SCROLL_STEP = 1,
  parameter int CELL_LOG2   = 5
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               pixel_valid,
  input  logic               frame_start,
  input  logic [1:0]         mode,
  input  logic               mode_load,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               out_valid
);

  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  localparam int OFF_W = $clog2(H_ACTIVE);
  localparam int SUM_W = OFF_W + 1;
  localparam int IDX_W = ($clog2(NUM_BARS) > 3) ? $clog2(NUM_BARS) : 3;
  localparam logic [COLOR_W-1:0] FULL = '1;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_SCROLL  = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_RAMP    = 2'd3
  } mode_e;

  // Frame-level pattern state
  mode_e             pending_mode_q, pending_mode_d;
  mode_e             active_mode_q, active_mode_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [SUM_W-1:0]  step_sum;

  // Stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic [9:0]        s1_x_q, s1_x_d;
  logic [OFF_W-1:0]  s1_xs_q, s1_xs_d;
  logic              s1_ycell_q, s1_ycell_d;
  logic              s1_phase_q, s1_phase_d;
  mode_e             s1_mode_q, s1_mode_d;
  logic [SUM_W-1:0]  xs_sum;

  // Stage 2 (output) registers
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   bar_idx;
  logic [COLOR_W-1:0] ramp_val;

  // Bars are counted by boundary crossings so remainder pixels fall into the last bar.
  function automatic logic [IDX_W-1:0] bar_of(input logic [15:0] col);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (col >= 16'(k * BAR_W)) idx = idx + IDX_W'(1);
    end
    return idx;
  endfunction

  always_comb begin
    pending_mode_d = pending_mode_q;
    active_mode_d  = active_mode_q;
    offset_d       = offset_q;
    frame_cnt_d    = frame_cnt_q;
    step_sum       = SUM_W'(offset_q) + SUM_W'(SCROLL_STEP);
    if (mode_load) pending_mode_d = mode_e'(mode);
    if (frame_start) begin
      active_mode_d = pending_mode_q;
      frame_cnt_d   = frame_cnt_q + 8'd1;
      if (pending_mode_q == MODE_SCROLL) begin
        if (step_sum >= SUM_W'(H_ACTIVE)) offset_d = OFF_W'(step_sum - SUM_W'(H_ACTIVE));
        else                              offset_d = OFF_W'(step_sum);
      end
    end
  end

  // Stage 1 samples the pre-update frame state, so a pixel coinciding with frame_start keeps the old pattern.
  always_comb begin
    s1_valid_d = pixel_valid && (32'(x) < 32'(H_ACTIVE)) && (32'(y) < 32'(V_ACTIVE));
    xs_sum     = SUM_W'(x) + SUM_W'(offset_q);
    if (xs_sum >= SUM_W'(H_ACTIVE)) s1_xs_d = OFF_W'(xs_sum - SUM_W'(H_ACTIVE));
    else                            s1_xs_d = OFF_W'(xs_sum);
    s1_x_d     = x;
    s1_ycell_d = y[CELL_LOG2];
    s1_phase_d = frame_cnt_q[5];
    s1_mode_d  = active_mode_q;
  end

  always_comb begin
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    out_valid_d = s1_valid_q;
    bar_idx     = bar_of((s1_mode_q == MODE_SCROLL) ? 16'(s1_xs_q) : 16'(s1_x_q));
    if (32'(s1_x_q) > 32'((1 << COLOR_W) - 1)) ramp_val = FULL;
    else                                       ramp_val = COLOR_W'(s1_x_q);
    if (s1_valid_q) begin
      case (s1_mode_q)
        MODE_BARS, MODE_SCROLL: begin
          red_d   = bar_idx[0] ? FULL : '0;
          green_d = bar_idx[1] ? FULL : '0;
          blue_d  = bar_idx[2] ? FULL : '0;
        end
        MODE_CHECKER: begin
          if (s1_x_q[CELL_LOG2] ^ s1_ycell_q ^ s1_phase_q) begin
            red_d   = FULL;
            green_d = FULL;
            blue_d  = FULL;
          end
        end
        default: begin
          red_d   = ramp_val;
          green_d = ramp_val;
          blue_d  = ramp_val;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending_mode_q <= MODE_BARS;
      active_mode_q  <= MODE_BARS;
      offset_q       <= '0;
      frame_cnt_q    <= '0;
      s1_valid_q     <= 1'b0;
      s1_x_q         <= '0;
      s1_xs_q        <= '0;
      s1_ycell_q     <= 1'b0;
      s1_phase_q     <= 1'b0;
      s1_mode_q      <= MODE_BARS;
      red_q          <= '0;
      green_q        <= '0;
      blue_q         <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      pending_mode_q <= pending_mode_d;
      active_mode_q  <= active_mode_d;
      offset_q       <= offset_d;
      frame_cnt_q    <= frame_cnt_d;
      s1_valid_q     <= s1_valid_d;
      s1_x_q         <= s1_x_d;
      s1_xs_q        <= s1_xs_d;
      s1_ycell_q     <= s1_ycell_d;
      s1_phase_q     <= s1_phase_d;
      s1_mode_q      <= s1_mode_d;
      red_q          <= red_d;
      green_q        <= green_d;
      blue_q         <= blue_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: dut_a uses SCROLL_STEP=1, dut_b uses SCROLL_STEP=7.
// Stimulus tasks queue hand-computed expectations; per-DUT monitors pop and compare on the due cycle.
module tb_test_pattern_gen;

  typedef struct {
    int         due;
    int         tag;
    logic       v;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } exp_t;

  localparam logic [9:0] F = 10'h3FF;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       pv_a = 1'b0;
  logic       pv_b = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] mode = '0;
  logic       mode_load = 1'b0;
  logic [9:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic       out_valid_a, out_valid_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   tag_n = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t e_a, e_b;

  test_pattern_gen dut_a (
    .clock(clock), .resetn(resetn), .x(x), .y(y), .pixel_valid(pv_a),
    .frame_start(frame_start), .mode(mode), .mode_load(mode_load),
    .red(red_a), .green(green_a), .blue(blue_a), .out_valid(out_valid_a)
  );

  test_pattern_gen #(.SCROLL_STEP(7)) dut_b (
    .clock(clock), .resetn(resetn), .x(x), .y(y), .pixel_valid(pv_b),
    .frame_start(frame_start), .mode(mode), .mode_load(mode_load),
    .red(red_b), .green(green_b), .blue(blue_b), .out_valid(out_valid_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t px(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    exp_t e;
    e.due = 0; e.tag = 0; e.v = 1'b1; e.r = r; e.g = g; e.b = b;
    return e;
  endfunction

  function automatic exp_t inv();
    exp_t e;
    e.due = 0; e.tag = 0; e.v = 1'b0; e.r = '0; e.g = '0; e.b = '0;
    return e;
  endfunction

  function automatic exp_t grey(input logic [9:0] n);
    return px(n, n, n);
  endfunction

  task automatic checkOutput(input string name, input exp_t e, input logic v,
                             input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    checks++;
    if (v !== e.v || r !== e.r || g !== e.g || b !== e.b) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%0b rgb=%03h/%03h/%03h, want valid=%0b rgb=%03h/%03h/%03h",
               name, v, r, g, b, e.v, e.r, e.g, e.b);
    end
  endtask

  // One pixel cycle; ca/cb select which DUT renders it and gets an expectation queued.
  task automatic applyStimulus(input logic [9:0] px_x, input logic [9:0] px_y, input logic fs,
                               input logic ca, input exp_t ea, input logic cb, input exp_t eb);
    @(posedge clock); #1;
    x = px_x; y = px_y; frame_start = fs; mode_load = 1'b0;
    pv_a = ca; pv_b = cb;
    tag_n++;
    if (ca) begin ea.due = cyc + 2; ea.tag = tag_n; qa.push_back(ea); end
    if (cb) begin eb.due = cyc + 2; eb.tag = tag_n; qb.push_back(eb); end
  endtask

  task automatic pix_a(input logic [9:0] px_x, input logic [9:0] px_y, input exp_t e);
    applyStimulus(px_x, px_y, 1'b0, 1'b1, e, 1'b0, inv());
  endtask

  task automatic pix_b(input logic [9:0] px_x, input logic [9:0] px_y, input exp_t e);
    applyStimulus(px_x, px_y, 1'b0, 1'b0, inv(), 1'b1, e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      pv_a = 1'b0; pv_b = 1'b0; frame_start = 1'b0; mode_load = 1'b0;
    end
  endtask

  task automatic load_mode(input logic [1:0] m);
    @(posedge clock); #1;
    pv_a = 1'b0; pv_b = 1'b0; frame_start = 1'b0; mode = m; mode_load = 1'b1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      pv_a = 1'b0; pv_b = 1'b0; mode_load = 1'b0; frame_start = 1'b1;
      @(posedge clock); #1;
      frame_start = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      if (qa.size() != 0 && qa[0].due < cyc) begin
        e_a = qa.pop_front();
        checks++; errors++;
        $display("[TB] FAIL A#%0d missed: got no output at cycle %0d, want output", e_a.tag, e_a.due);
      end
      if (qa.size() != 0 && qa[0].due == cyc) begin
        e_a = qa.pop_front();
        checkOutput($sformatf("A#%0d", e_a.tag), e_a, out_valid_a, red_a, green_a, blue_a);
      end else if (out_valid_a) begin
        checks++; errors++;
        $display("[TB] FAIL A unexpected: got out_valid=1 at cycle %0d, want 0", cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      if (qb.size() != 0 && qb[0].due < cyc) begin
        e_b = qb.pop_front();
        checks++; errors++;
        $display("[TB] FAIL B#%0d missed: got no output at cycle %0d, want output", e_b.tag, e_b.due);
      end
      if (qb.size() != 0 && qb[0].due == cyc) begin
        e_b = qb.pop_front();
        checkOutput($sformatf("B#%0d", e_b.tag), e_b, out_valid_b, red_b, green_b, blue_b);
      end else if (out_valid_b) begin
        checks++; errors++;
        $display("[TB] FAIL B unexpected: got out_valid=1 at cycle %0d, want 0", cyc);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_a", inv(), out_valid_a, red_a, green_a, blue_a);
    checkOutput("reset_b", inv(), out_valid_b, red_b, green_b, blue_b);
    resetn = 1'b1;
    idle_cycles(2);

    // Static bars, frame_cnt 0, offset 0
    pix_a(0, 0, px(0, 0, 0));
    pix_a(80, 0, px(F, 0, 0));
    pix_a(79, 0, px(0, 0, 0));
    pix_a(159, 5, px(F, 0, 0));
    pix_a(160, 5, px(0, F, 0));
    pix_a(480, 0, px(0, F, F));
    pix_a(639, 479, px(F, F, F));
    pix_a(640, 0, inv());
    applyStimulus(80, 0, 1'b0, 1'b1, px(F, 0, 0), 1'b1, px(F, 0, 0));

    // Checkerboard: mid-frame load does not affect the current frame
    load_mode(2'd2);
    pix_a(80, 0, px(F, 0, 0));
    frames(1);
    pix_a(0, 0, px(0, 0, 0));
    pix_a(32, 0, px(F, F, F));
    pix_a(31, 0, px(0, 0, 0));
    pix_a(0, 32, px(F, F, F));
    pix_a(32, 32, px(0, 0, 0));
    frames(31);
    pix_a(0, 0, px(F, F, F));
    pix_a(32, 0, px(0, 0, 0));
    frames(223);
    pix_a(0, 0, px(F, F, F));
    applyStimulus(0, 0, 1'b1, 1'b1, px(F, F, F), 1'b0, inv());
    pix_a(0, 0, px(0, 0, 0));

    // Grey ramp; the later of two loads wins
    load_mode(2'd1);
    load_mode(2'd3);
    frames(1);
    pix_a(300, 0, grey(300));
    pix_a(0, 0, grey(0));
    pix_a(639, 479, grey(639));
    pix_a(700, 0, inv());
    pix_a(300, 480, inv());
    applyStimulus(300, 10, 1'b0, 1'b1, grey(300), 1'b1, grey(300));

    // Scrolling bars
    load_mode(2'd1);
    pix_a(80, 0, grey(80));
    frames(1);
    pix_a(79, 0, px(F, 0, 0));
    pix_a(78, 0, px(0, 0, 0));
    pix_a(639, 0, px(0, 0, 0));
    pix_b(73, 0, px(F, 0, 0));
    pix_b(72, 0, px(0, 0, 0));
    applyStimulus(78, 0, 1'b1, 1'b1, px(0, 0, 0), 1'b1, px(F, 0, 0));
    pix_a(78, 0, px(F, 0, 0));
    pix_b(65, 0, px(0, 0, 0));
    pix_b(66, 0, px(F, 0, 0));
    frames(638);
    pix_a(80, 0, px(F, 0, 0));
    pix_a(79, 0, px(0, 0, 0));
    pix_a(0, 0, px(0, 0, 0));
    pix_b(79, 0, px(0, 0, 0));
    pix_b(80, 0, px(F, 0, 0));
    frames(91);
    pix_b(2, 0, px(F, F, F));
    pix_b(3, 0, px(0, 0, 0));
    pix_a(0, 0, px(F, 0, 0));
    pix_a(68, 0, px(F, 0, 0));
    pix_a(69, 0, px(0, F, 0));
    frames(1);
    pix_b(76, 0, px(F, 0, 0));
    pix_b(75, 0, px(0, 0, 0));
    pix_a(68, 0, px(0, F, 0));
    pix_a(67, 0, px(F, 0, 0));

    // Asynchronous reset with pixels in flight (offset 92 on dut_a: x=300 lands in bar 4)
    idle_cycles(3);
    @(posedge clock); #1;
    x = 300; y = 0; pv_a = 1'b1; pv_b = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #2;
    checkOutput("pre_reset_a", px(0, 0, F), out_valid_a, red_a, green_a, blue_a);
    resetn = 1'b0; pv_a = 1'b0; pv_b = 1'b0;
    #1;
    checkOutput("async_reset_a", inv(), out_valid_a, red_a, green_a, blue_a);
    checkOutput("async_reset_b", inv(), out_valid_b, red_b, green_b, blue_b);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    idle_cycles(3);
    pix_a(80, 0, px(F, 0, 0));
    pix_b(80, 0, px(F, 0, 0));
    load_mode(2'd1);
    frames(1);
    pix_a(79, 0, px(F, 0, 0));
    pix_a(78, 0, px(0, 0, 0));
    pix_b(73, 0, px(F, 0, 0));
    pix_b(72, 0, px(0, 0, 0));
    idle_cycles(4);

    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_a: got %0d pending entries, want 0", qa.size());
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_b: got %0d pending entries, want 0", qb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
